// File: rtl/sensor_sample_sequencer_pkg.sv
// Shared types and constants for the six-channel sensor acquisition sequencer.
package sensor_seq_pkg;

    localparam int unsigned NUM_CH = 6;
    localparam int unsigned SLOT_W = 8;
    localparam int unsigned BOUT_W = NUM_CH * SLOT_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_COMMIT,
        ST_WAIT_CALC,
        ST_CAPTURE
    } state_t;

    typedef enum logic [2:0] {
        CH_BPX,
        CH_BMX,
        CH_BPY,
        CH_BMY,
        CH_BPZ,
        CH_BMZ
    } ch_t;

    // Bit offset of each channel's byte inside b_out, indexed by ch_t.
    localparam int unsigned SLOT_LSB [NUM_CH] = '{0, 8, 16, 24, 32, 40};

endpackage

// File: rtl/sensor_sample_sequencer_if.sv
// Shared ADC request/acknowledge port; the sequencer is master, the ADC is slave.
interface sensor_sample_sequencer_if;
    logic              adc_req;
    logic [2:0]        adc_ch;
    logic              adc_ack;
    logic signed [7:0] adc_data;

    modport master (output adc_req, output adc_ch, input adc_ack, input adc_data);
    modport slave  (input adc_req, input adc_ch, output adc_ack, output adc_data);
endinterface

// File: rtl/sensor_sample_sequencer_tmr_vote3.sv
// Bitwise 2-of-3 majority voter; o_mismatch flags any disagreement between copies.
module tmr_vote3 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_y,
    output logic             o_mismatch
);
    assign o_y        = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_mismatch = |((i_a ^ i_b) | (i_a ^ i_c));
endmodule

// File: rtl/sensor_sample_sequencer.sv
// Six-channel ADC acquisition sequencer feeding a coherent sample set to calculator.
// Define SEQ_TMR_EN to triplicate the FSM state, channel and wait counters.
module sensor_sample_sequencer
    import sensor_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned PERIOD         = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      auto_en,
    sensor_sample_sequencer_if.master adc,
    output logic [BOUT_W-1:0]         b_out,
    input  logic signed [15:0]        calc_psi,
    input  logic signed [15:0]        calc_theta,
    output logic signed [15:0]        omega_psi,
    output logic signed [15:0]        omega_theta,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      err_timeout,
    input  logic                      err_clr,
    output logic                      tmr_err
);

    localparam int unsigned     PCW       = $clog2(PERIOD);
    localparam logic [PCW-1:0]  P_LAST    = PCW'(PERIOD - 1);
    localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      w_state, w_state_nxt;
    logic [2:0]  w_ch, w_ch_nxt;
    logic [15:0] w_wait, w_wait_nxt;
    logic        w_tick, w_timeout, w_req, w_commit, w_capture, w_busy;

    logic [PCW-1:0]    r_period;
    logic [SLOT_W-1:0] r_shadow [NUM_CH];
    logic [BOUT_W-1:0] r_b_out;
    logic [15:0]       r_omega_psi, r_omega_theta;
    logic              r_out_valid, r_err_timeout;

    assign w_tick    = auto_en && (r_period == P_LAST);
    assign w_timeout = (w_state == ST_REQ) && !adc.adc_ack && (w_wait == WAIT_LAST);

    // State, channel and wait-counter registers (plain or triplicated).
`ifdef SEQ_TMR_EN
    logic [2:0]  r_state_tmr [3];
    logic [2:0]  r_ch_tmr    [3];
    logic [15:0] r_wait_tmr  [3];
    logic [2:0]  w_state_vote;
    logic        w_state_mis, w_ch_mis, w_wait_mis;
    logic        r_tmr_err;

    tmr_vote3 #(.WIDTH(3)) u_vote_state (
        .i_a(r_state_tmr[0]), .i_b(r_state_tmr[1]), .i_c(r_state_tmr[2]),
        .o_y(w_state_vote), .o_mismatch(w_state_mis));
    tmr_vote3 #(.WIDTH(3)) u_vote_ch (
        .i_a(r_ch_tmr[0]), .i_b(r_ch_tmr[1]), .i_c(r_ch_tmr[2]),
        .o_y(w_ch), .o_mismatch(w_ch_mis));
    tmr_vote3 #(.WIDTH(16)) u_vote_wait (
        .i_a(r_wait_tmr[0]), .i_b(r_wait_tmr[1]), .i_c(r_wait_tmr[2]),
        .o_y(w_wait), .o_mismatch(w_wait_mis));

    assign w_state = state_t'(w_state_vote);
    assign tmr_err = r_tmr_err;

    // Writing the voted next value into every copy scrubs a single upset each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_state_tmr[i] <= ST_IDLE;
                r_ch_tmr[i]    <= '0;
                r_wait_tmr[i]  <= '0;
            end
            r_tmr_err <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_state_tmr[i] <= w_state_nxt;
                r_ch_tmr[i]    <= w_ch_nxt;
                r_wait_tmr[i]  <= w_wait_nxt;
            end
            r_tmr_err <= r_tmr_err | w_state_mis | w_ch_mis | w_wait_mis;
        end
    end
`else
    state_t      r_state;
    logic [2:0]  r_ch;
    logic [15:0] r_wait;

    assign w_state = r_state;
    assign w_ch    = r_ch;
    assign w_wait  = r_wait;
    assign tmr_err = 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_wait  <= w_wait_nxt;
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = w_state;
        w_ch_nxt    = w_ch;
        w_wait_nxt  = '0;
        case (w_state)
            ST_IDLE: begin
                if (start || w_tick) begin
                    w_state_nxt = ST_REQ;
                    w_ch_nxt    = '0;
                end
            end
            ST_REQ: begin
                if (adc.adc_ack || w_timeout) w_state_nxt = ST_GAP;
                else                          w_wait_nxt  = w_wait + 16'd1;
            end
            ST_GAP: begin
                if (w_ch == 3'(CH_BMZ)) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_ch_nxt    = w_ch + 3'd1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_COMMIT:    w_state_nxt = ST_WAIT_CALC;
            ST_WAIT_CALC: w_state_nxt = ST_CAPTURE;
            ST_CAPTURE:   w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req     = 1'b0;
        w_commit  = 1'b0;
        w_capture = 1'b0;
        w_busy    = (w_state != ST_IDLE);
        case (w_state)
            ST_REQ:     w_req     = 1'b1;
            ST_COMMIT:  w_commit  = 1'b1;
            ST_CAPTURE: w_capture = 1'b1;
            default:    ;
        endcase
    end

    // NOTE: the shadow slots are reset too, so an aborted acquisition never leaks stale samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period      <= '0;
            for (int i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
            r_b_out       <= '0;
            r_omega_psi   <= '0;
            r_omega_theta <= '0;
            r_out_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (!auto_en || w_tick) r_period <= '0;
            else                    r_period <= r_period + 1'b1;

            if (w_req && adc.adc_ack) r_shadow[w_ch] <= adc.adc_data;
            else if (w_timeout)       r_shadow[w_ch] <= '0;

            if (w_commit) begin
                for (int i = 0; i < NUM_CH; i++) r_b_out[SLOT_LSB[i] +: SLOT_W] <= r_shadow[i];
            end

            r_out_valid <= w_capture;
            if (w_capture) begin
                r_omega_psi   <= calc_psi;
                r_omega_theta <= calc_theta;
            end

            // A timeout in the same cycle as err_clr keeps the flag set.
            if (w_timeout)    r_err_timeout <= 1'b1;
            else if (err_clr) r_err_timeout <= 1'b0;
        end
    end

    assign adc.adc_req  = w_req;
    assign adc.adc_ch   = w_ch;
    assign b_out        = r_b_out;
    assign omega_psi    = r_omega_psi;
    assign omega_theta  = r_omega_theta;
    assign out_valid    = r_out_valid;
    assign busy         = w_busy;
    assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_sensor_sample_sequencer.sv
// Directed, scoreboard-based bench for sensor_sample_sequencer (TIMEOUT_CYCLES=4, PERIOD=100).
module tb_sensor_sample_sequencer;
    import sensor_seq_pkg::*;

    localparam logic [47:0] B_RAMP = 48'h3329_1F15_0B01;
    localparam logic [47:0] B_TO3  = 48'h3329_0015_0B01;

    typedef struct {
        logic [47:0] b;
        logic [31:0] start_edge;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic auto_en = 1'b0;
    logic err_clr = 1'b0;
    logic [47:0] b_out;
    logic signed [15:0] omega_psi, omega_theta;
    logic out_valid, busy, err_timeout, tmr_err;
    logic [31:0] cyc = '0;
    logic data_mode = 1'b0;
    logic [2:0] skip_ch = 3'd7;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    exp_t sb[$];

    sensor_sample_sequencer_if adc_if ();

    sensor_sample_sequencer #(.TIMEOUT_CYCLES(4), .PERIOD(100)) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .adc(adc_if.master),
        .b_out(b_out), .calc_psi(cyc[15:0]), .calc_theta(~cyc[15:0]),
        .omega_psi(omega_psi), .omega_theta(omega_theta), .out_valid(out_valid),
        .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr), .tmr_err(tmr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ADC: zero-wait ack except on skip_ch; ramp or per-cycle-varying data.
    assign adc_if.adc_ack  = adc_if.adc_req && (adc_if.adc_ch != skip_ch);
    assign adc_if.adc_data = data_mode ? (cyc[7:0] ^ 8'h5A)
                                       : (({5'd0, adc_if.adc_ch} * 8'd10) + 8'd1);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; se is the counter value of the edge that samples it.
    task automatic do_start(output logic [31:0] se);
        @(negedge clk);
        start = 1'b1;
        se    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_at(input logic [31:0] t);
        while (cyc != t) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [47:0] b, input logic [31:0] se, input int lat);
        exp_t x;
        x.b = b; x.start_edge = se; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        logic [15:0] p;
        exp_t x;
        if (!rst && out_valid) begin
            e = cyc - 1;
            n_out++;
            check("out_valid_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                p = 16'(x.start_edge + 32'(x.lat));
                check("b_out", 64'(b_out), 64'(x.b));
                check("latency", 64'(e - x.start_edge), 64'(x.lat));
                check("omega_psi", 64'(omega_psi), 64'(p));
                check("omega_theta", 64'(omega_theta), 64'(~p));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] se, a1, t;
        logic [47:0] b_new;
        int n0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_adc_req", 64'(adc_if.adc_req), 64'd0);
        check("rst_adc_ch", 64'(adc_if.adc_ch), 64'd0);
        check("rst_b_out", 64'(b_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flags", 64'({err_timeout, tmr_err, out_valid}), 64'd0);
        check("rst_omega", 64'({omega_psi, omega_theta}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait ramp acquisition.
        do_start(se);
        push(B_RAMP, se, 15);
        #1;
        check("req_after_start", 64'({adc_if.adc_req, adc_if.adc_ch}), 64'h8);
        check("busy_after_start", 64'(busy), 64'd1);
        drain();
        check("no_timeout", 64'(err_timeout), 64'd0);
        check("idle_after", 64'(busy), 64'd0);

        // b_out stability while ADC data changes every cycle.
        data_mode = 1'b1;
        do_start(se);
        b_new = '0;
        for (int c = 0; c < 6; c++) begin
            t = se + 32'(1 + 2 * c);
            b_new[c*8 +: 8] = t[7:0] ^ 8'h5A;
        end
        push(b_new, se, 15);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b_out_stable_k%0d", k), 64'(b_out), 64'((k >= 13) ? b_new : B_RAMP));
        end
        drain();
        data_mode = 1'b0;

        // Channel 3 never acknowledged.
        skip_ch = 3'd3;
        do_start(se);
        push(B_TO3, se, 18);
        drain();
        check("err_timeout_set", 64'(err_timeout), 64'd1);
        skip_ch = 3'd7;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_timeout_clr", 64'(err_timeout), 64'd0);

        // Auto mode: one acquisition per period, busy start dropped, start+tick merged.
        n0 = n_out;
        @(negedge clk);
        auto_en = 1'b1;
        @(posedge clk);
        #1;
        a1 = cyc - 1;
        push(B_RAMP, a1 + 99, 15);
        push(B_RAMP, a1 + 199, 15);
        push(B_RAMP, a1 + 299, 15);
        pulse_at(a1 + 202);
        pulse_at(a1 + 299);
        drain();
        @(negedge clk);
        auto_en = 1'b0;
        repeat (120) @(negedge clk);
        check("auto_count", 64'(n_out - n0), 64'd3);

        // Reset in REQ on channel 2, then restart from channel 0.
        do_start(se);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_req_ch2", 64'({adc_if.adc_req, adc_if.adc_ch}), 64'hA);
        rst = 1'b1;
        #1;
        check("midrst_adc_req", 64'(adc_if.adc_req), 64'd0);
        check("midrst_adc_ch", 64'(adc_if.adc_ch), 64'd0);
        check("midrst_b_out", 64'(b_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_omega", 64'({omega_psi, omega_theta}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start(se);
        push(B_RAMP, se, 15);
        #1;
        check("restart_ch0", 64'({adc_if.adc_req, adc_if.adc_ch}), 64'h8);
        drain();

`ifdef SEQ_TMR_EN
        // Single-copy upset on the state register mid-sequence.
        do_start(se);
        push(B_RAMP, se, 15);
        repeat (3) @(posedge clk);
        #1;
        dut.r_state_tmr[1] = 3'(ST_CAPTURE);
        drain();
        check("tmr_err_set", 64'(tmr_err), 64'd1);
`else
        check("tmr_err_tied", 64'(tmr_err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_sample_sequencer.md
# sensor_sample_sequencer

Acquisition controller in front of the `calculator` attitude-rate datapath. It sequences the six differential field channels (+X, −X, +Y, −Y, +Z, −Z) through one shared ADC request/acknowledge port, with a per-request timeout for radiation-induced hangs. It presents all six samples to `calculator` at once, so the datapath only ever sees a coherent sample set. It then captures the resulting `omegaPsi`/`omegaTheta` pair with a valid strobe.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles for `adc_ack` per request (1..65535).
- `PERIOD`, default 1000: auto-mode acquisition period in clk cycles (≥ 32).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins an acquisition; ignored while `busy`.
- `auto_en`  in  1  enables periodic self-start every `PERIOD` cycles.
- `adc_req`  out  1  request to the ADC.
- `adc_ch`  out  3  channel index: 0=+X, 1=−X, 2=+Y, 3=−Y, 4=+Z, 5=−Z.
- `adc_ack`  in  1  ADC acknowledge; `adc_data` is valid in the same cycle.
- `adc_data`  in  8  signed sample.
- `b_out`  out  48  samples to `calculator`; [7:0]=BplusX, [15:8]=BminX, [23:16]=BplusY, [31:24]=BminY, [39:32]=BplusZ, [47:40]=BminZ.
- `calc_psi`, `calc_theta`  in  16 each  `calculator` outputs (signed).
- `omega_psi`, `omega_theta`  out  16 each  captured result.
- `out_valid`  out  1  one-cycle strobe when a new result is captured.
- `busy`  out  1  high from the accepted start until `out_valid`.
- `err_timeout`  out  1  sticky flag: at least one ADC request timed out.
- `err_clr`  in  1  clears `err_timeout`.
- `tmr_err`  out  1  sticky flag for a TMR copy disagreement (see Configuration).

## Operation
- FSM states: IDLE, REQ, GAP, COMMIT, WAIT_CALC, CAPTURE.
- IDLE: go to REQ with channel 0 on `start`, or on the auto tick when `auto_en` is high.
- REQ:
  - `adc_req`=1 and `adc_ch` holds the current channel, both stable until the request ends.
  - On `adc_ack`=1, latch `adc_data` into shadow slot[ch], then go to GAP.
  - If the wait counter reaches `TIMEOUT_CYCLES` with no ack:
    - write slot[ch]=0 and set `err_timeout`;
    - go to GAP.
- GAP: one idle cycle with `adc_req`=0. If ch<5, increment ch and go to REQ; otherwise go to COMMIT.
- COMMIT: copy all six shadow slots into `b_out` in a single edge.
- WAIT_CALC: one cycle while the `calculator` register loads.
- CAPTURE: `omega_psi`/`omega_theta` ← `calc_psi`/`calc_theta`, pulse `out_valid`, return to IDLE.
- `b_out` changes only in COMMIT. Shadow slots and `b_out` are plain copies with no arithmetic.
- Auto tick:
  - The period counter runs 0..PERIOD−1 while `auto_en` is high and holds at 0 when it is low.
  - The tick fires at the terminal count.
  - A tick that arrives while `busy` is dropped and is not queued.
- Simultaneous events:
  - `err_clr` and a new timeout in the same cycle: set wins.
  - `start` and auto tick in the same cycle: one acquisition starts.
- Reset mid-operation: all state returns to its reset value immediately. `adc_req` drops asynchronously, and any late `adc_ack` in IDLE is ignored.

## Timing
- Reset values: every output is 0, including `b_out`, `adc_ch`, and both flags.
- `adc_req` rises on the edge after the start is accepted.
- ADC acknowledge with zero wait: each channel takes 2 cycles (REQ + GAP).
- Acquisition latency, start edge to `out_valid` high, with zero-wait ADC: 6×2 + 3 = 15 cycles.
- Each wait cycle adds one cycle of latency.
- A timed-out channel costs `TIMEOUT_CYCLES` + 1 (GAP) cycles.
- `calc_psi`/`calc_theta` are sampled exactly 2 edges after the COMMIT edge.

## Configuration
- `SEQ_TMR_EN` defined:
  - The FSM state, channel counter and wait counter are triplicated.
  - Each is read through a bitwise 2-of-3 majority vote.
  - The voted next value is written to all three copies every cycle, which scrubs single upsets.
  - Any copy disagreement sets `tmr_err` until reset.
- `SEQ_TMR_EN` undefined: single registers, and `tmr_err` is tied to 0.

## Structure
- `sensor_seq_pkg`: state enum, channel enum (`CH_BPX`..`CH_BMZ`), `NUM_CH`=6, and the `b_out` slot-offset constants.
- Sub-module `tmr_vote3`: parameterised-width majority voter with a mismatch output. It is instantiated only under `SEQ_TMR_EN`.

## Test plan
- Zero-wait ADC returning ch*10+1 → `b_out` = 0x33_29_1F_15_0B_01 (bytes −Z..+X), `out_valid` 15 cycles after start, `omega_*` equal to the `calc_*` value 2 edges after COMMIT.
- ADC never acks channel 3, `TIMEOUT_CYCLES`=4 → slot 3 = 0, `err_timeout`=1, and the remaining channels complete. `err_clr` then clears the flag.
- `auto_en`=1, `PERIOD`=100, zero-wait ADC → `out_valid` every 100 cycles. `start` pulsed while busy → no extra acquisition.
- `rst` asserted while in REQ on channel 2 → `adc_req`=0 immediately, all outputs 0. A subsequent `start` begins again at channel 0.
- Check that `b_out` is stable during REQ/GAP, with ADC data changing every cycle → `b_out` changes only on the COMMIT edge.
- `SEQ_TMR_EN`: force one copy of the state register to a wrong value mid-sequence → the sequence completes correctly and `tmr_err`=1.
